// File: rtl/zion_lsu_pkg.sv
// Shared types and helpers for the zion load/store controller.
// Optional split of word-crossing misaligned accesses: ZION_LSU_MISALIGN_SPLIT_EN.
package zion_lsu_pkg;

   typedef enum logic [1:0] {
      BYTE   = 2'd0,
      HALF   = 2'd1,
      WORD   = 2'd2,
      DOUBLE = 2'd3
   } memWidthT;

   typedef enum logic [1:0] {
      FLT_NONE     = 2'd0,
      FLT_BUS      = 2'd1,
      FLT_MISALIGN = 2'd2,
      FLT_ILLEGAL  = 2'd3
   } faultT;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ0 = 3'd1,
      RSP0 = 3'd2,
      REQ1 = 3'd3,
      RSP1 = 3'd4,
      DONE = 3'd5
   } lsuStateT;

   function automatic logic [7:0] sizeMask(input memWidthT w);
      case (w)
         BYTE:    return 8'h01;
         HALF:    return 8'h03;
         WORD:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] alignMask(input memWidthT w);
      case (w)
         BYTE:    return 3'd0;
         HALF:    return 3'd1;
         WORD:    return 3'd3;
         default: return 3'd7;
      endcase
   endfunction

endpackage

// File: rtl/zion_lsu_load_align.sv
// Combinational load data extraction: joins the beat data, right-justifies the
// addressed bytes and sign- or zero-extends them to the datapath width.
module zion_lsu_load_align
   import zion_lsu_pkg::*;
#(
   parameter  int DW = 32,
   localparam int SB = DW / 8,
   localparam int OW = $clog2(SB)
) (
   input  logic [DW-1:0] beat0Dat,
   input  logic [DW-1:0] beat1Dat,
   input  logic [OW-1:0] offset,
   input  memWidthT      width,
   input  logic          unsignedFlg,
   output logic [DW-1:0] loadDat
);

   logic [DW-1:0] raw;
   logic [DW-1:0] keep;
   logic          sgn;

   always_comb begin
      // Beat-1 bytes sit above beat-0 bytes, so one right shift aligns both cases.
      raw  = DW'({beat1Dat, beat0Dat} >> {offset, 3'b000});
      keep = '1;
      sgn  = raw[DW-1];
      case (width)
         BYTE: begin
            keep = DW'(8'hFF);
            sgn  = raw[7];
         end
         HALF: begin
            keep = DW'(16'hFFFF);
            sgn  = raw[15];
         end
         WORD: begin
            keep = DW'(32'hFFFF_FFFF);
            sgn  = raw[31];
         end
         default: begin
            keep = '1;
            sgn  = raw[DW-1];
         end
      endcase
      loadDat = (raw & keep) | ({DW{sgn & ~unsignedFlg}} & ~keep);
   end

endmodule

// File: rtl/zion_lsu_ctrl.sv
// Single-outstanding load/store sequencer towards a valid/ready data bus.
// ZION_LSU_MISALIGN_SPLIT_EN enables two-beat execution of word-crossing accesses.
//
// state | meaning
// IDLE  | ready for a request, decode on acceptance
// REQ0  | first (or only) bus beat request pending
// RSP0  | waiting for first beat response
// REQ1  | second beat request at next bus word (split build only)
// RSP1  | waiting for second beat response (split build only)
// DONE  | one-cycle completion with result and fault code
module zion_lsu_ctrl
   import zion_lsu_pkg::*;
#(
   parameter  int RV64 = 0,
   localparam int DW   = 32 * (1 + RV64),
   localparam int SB   = DW / 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          memEn,
   input  logic          load,
   input  logic          store,
   input  logic          unsignedFlg,
   input  logic [1:0]    memWidth,
   input  logic [DW-1:0] storeDat,
   input  logic [DW-1:0] memAddr,
   output logic          reqRdy,
   output logic          busReqVld,
   input  logic          busReqRdy,
   output logic          busWe,
   output logic [DW-1:0] busAddr,
   output logic [DW-1:0] busWdat,
   output logic [SB-1:0] busStrb,
   input  logic          busRspVld,
   input  logic [DW-1:0] busRdat,
   input  logic          busRspErr,
   output logic          doneVld,
   output logic [DW-1:0] loadDat,
   output logic [1:0]    faultCode
);

   localparam int OW = $clog2(SB);

   lsuStateT      state, stateNxt;
   logic          outOfReset;
   logic          accept;

   memWidthT      inWidth;
   logic [OW-1:0] inOffset;
   logic [SB-1:0] inMask;
   logic [SB-1:0] inStrb0;
   logic [DW-1:0] inWdat0;
   logic          inIllegal;
   faultT         inFault;

   logic          rIsStore;
   logic          rUnsigned;
   memWidthT      rWidth;
   logic [OW-1:0] rOffset;
   logic [DW-1:0] rBase;
   logic [SB-1:0] rStrb0;
   logic [DW-1:0] rWdat0;
   logic [DW-1:0] rDat0;
   faultT         rFault;

   logic [DW-1:0] beat1Dat;
   logic [DW-1:0] alignedDat;

`ifdef ZION_LSU_MISALIGN_SPLIT_EN
   logic [SB-1:0] inStrb1;
   logic [DW-1:0] inWdat1;
   logic [SB-1:0] rStrb1;
   logic [DW-1:0] rWdat1;
   logic [DW-1:0] rDat1;
   logic          rCross;
`else
   logic          inMisal;
`endif

   assign inWidth   = memWidthT'(memWidth);
   assign inOffset  = memAddr[OW-1:0];
   assign inMask    = SB'(sizeMask(inWidth));
   assign inIllegal = (load == store) || (inWidth == DOUBLE && RV64 == 0);
   assign accept    = memEn && reqRdy;

   // Lane placement: anything shifted past the word boundary belongs to beat 1.
   always_comb begin
`ifdef ZION_LSU_MISALIGN_SPLIT_EN
      {inStrb1, inStrb0} = {{SB{1'b0}}, inMask} << inOffset;
      {inWdat1, inWdat0} = {{DW{1'b0}}, storeDat} << {inOffset, 3'b000};
`else
      inStrb0 = inMask << inOffset;
      inWdat0 = storeDat << {inOffset, 3'b000};
`endif
   end

`ifndef ZION_LSU_MISALIGN_SPLIT_EN
   assign inMisal = |(inOffset & OW'(alignMask(inWidth)));
`endif

   always_comb begin
      inFault = FLT_NONE;
      if (inIllegal) begin
         inFault = FLT_ILLEGAL;
      end
`ifndef ZION_LSU_MISALIGN_SPLIT_EN
      else if (inMisal) begin
         inFault = FLT_MISALIGN;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         outOfReset <= 1'b0;
      end else begin
         state      <= stateNxt;
         outOfReset <= 1'b1;
      end
   end

   always_comb begin
      stateNxt = state;
      case (state)
         IDLE: begin
            if (accept) stateNxt = (inFault != FLT_NONE) ? DONE : REQ0;
         end
         REQ0: begin
            if (busReqRdy) stateNxt = RSP0;
         end
         RSP0: begin
            if (busRspVld) begin
`ifdef ZION_LSU_MISALIGN_SPLIT_EN
               stateNxt = (!busRspErr && rCross) ? REQ1 : DONE;
`else
               stateNxt = DONE;
`endif
            end
         end
`ifdef ZION_LSU_MISALIGN_SPLIT_EN
         REQ1: begin
            if (busReqRdy) stateNxt = RSP1;
         end
         RSP1: begin
            if (busRspVld) stateNxt = DONE;
         end
`endif
         DONE:    stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rIsStore  <= 1'b0;
         rUnsigned <= 1'b0;
         rWidth    <= BYTE;
         rOffset   <= '0;
         rBase     <= '0;
         rStrb0    <= '0;
         rWdat0    <= '0;
         rDat0     <= '0;
         rFault    <= FLT_NONE;
`ifdef ZION_LSU_MISALIGN_SPLIT_EN
         rStrb1    <= '0;
         rWdat1    <= '0;
         rDat1     <= '0;
         rCross    <= 1'b0;
`endif
      end else begin
         if (accept) begin
            rIsStore  <= store;
            rUnsigned <= unsignedFlg;
            rWidth    <= inWidth;
            rOffset   <= inOffset;
            rBase     <= {memAddr[DW-1:OW], {OW{1'b0}}};
            rStrb0    <= inStrb0;
            rWdat0    <= inWdat0;
            rFault    <= inFault;
`ifdef ZION_LSU_MISALIGN_SPLIT_EN
            rStrb1    <= inStrb1;
            rWdat1    <= inWdat1;
            rCross    <= |inStrb1;
`endif
         end
         if (state == RSP0 && busRspVld) begin
            rDat0 <= busRdat;
            if (busRspErr) rFault <= FLT_BUS;
         end
`ifdef ZION_LSU_MISALIGN_SPLIT_EN
         if (state == RSP1 && busRspVld) begin
            rDat1 <= busRdat;
            if (busRspErr) rFault <= FLT_BUS;
         end
`endif
      end
   end

`ifdef ZION_LSU_MISALIGN_SPLIT_EN
   assign beat1Dat = rDat1;
`else
   assign beat1Dat = '0;
`endif

   zion_lsu_load_align #(
      .DW (DW)
   ) u_load_align (
      .beat0Dat    (rDat0),
      .beat1Dat    (beat1Dat),
      .offset      (rOffset),
      .width       (rWidth),
      .unsignedFlg (rUnsigned),
      .loadDat     (alignedDat)
   );

   always_comb begin
      reqRdy    = outOfReset && (state == IDLE);
      busReqVld = 1'b0;
      busWe     = 1'b0;
      busAddr   = '0;
      busStrb   = '0;
      busWdat   = '0;
      if (state == REQ0) begin
         busReqVld = 1'b1;
         busWe     = rIsStore;
         busAddr   = rBase;
         busStrb   = rStrb0;
         busWdat   = rWdat0;
      end
`ifdef ZION_LSU_MISALIGN_SPLIT_EN
      if (state == REQ1) begin
         busReqVld = 1'b1;
         busWe     = rIsStore;
         busAddr   = rBase + DW'(SB);
         busStrb   = rStrb1;
         busWdat   = rWdat1;
      end
`endif
      doneVld   = (state == DONE);
      faultCode = '0;
      loadDat   = '0;
      if (doneVld) begin
         faultCode = rFault;
         if (!rIsStore && rFault == FLT_NONE) loadDat = alignedDat;
      end
   end

endmodule

// File: tb/tb_zion_lsu_ctrl.sv
// Directed and randomized bench for zion_lsu_ctrl (RV32 datapath), checked
// against a byte-level reference model of the access.
module tb_zion_lsu_ctrl;

`ifdef ZION_LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        memEn, load, store, unsignedFlg;
   logic [1:0]  memWidth;
   logic [31:0] storeDat, memAddr;
   logic        reqRdy, busReqVld, busReqRdy, busWe;
   logic [31:0] busAddr, busWdat;
   logic [3:0]  busStrb;
   logic        busRspVld, busRspErr;
   logic [31:0] busRdat;
   logic        doneVld;
   logic [31:0] loadDat;
   logic [1:0]  faultCode;

   int nTests = 0;
   int nFail  = 0;

   always #5 clk = ~clk;

   zion_lsu_ctrl #(.RV64(0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .memEn       (memEn),
      .load        (load),
      .store       (store),
      .unsignedFlg (unsignedFlg),
      .memWidth    (memWidth),
      .storeDat    (storeDat),
      .memAddr     (memAddr),
      .reqRdy      (reqRdy),
      .busReqVld   (busReqVld),
      .busReqRdy   (busReqRdy),
      .busWe       (busWe),
      .busAddr     (busAddr),
      .busWdat     (busWdat),
      .busStrb     (busStrb),
      .busRspVld   (busRspVld),
      .busRdat     (busRdat),
      .busRspErr   (busRspErr),
      .doneVld     (doneVld),
      .loadDat     (loadDat),
      .faultCode   (faultCode)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chkAllZero(input string tag);
      chk({tag, " reqRdy"},    32'(reqRdy), 0);
      chk({tag, " busReqVld"}, 32'(busReqVld), 0);
      chk({tag, " busWe"},     32'(busWe), 0);
      chk({tag, " busAddr"},   busAddr, 0);
      chk({tag, " busStrb"},   32'(busStrb), 0);
      chk({tag, " busWdat"},   busWdat, 0);
      chk({tag, " doneVld"},   32'(doneVld), 0);
      chk({tag, " loadDat"},   loadDat, 0);
      chk({tag, " faultCode"}, 32'(faultCode), 0);
   endtask

   // One complete access; the model describes it byte by byte.
   task automatic runAccess(input string tag, input bit ld, input bit st, input bit uns,
         input logic [1:0] w, input logic [31:0] addr, input logic [31:0] sdat,
         input int reqDly, input int rspDly, input int errBeat,
         input logic [31:0] r0, input logic [31:0] r1);
      int          size, off, nb, fault, lane, beat;
      logic [3:0]  eStrb [2];
      logic [31:0] eWdat [2];
      logic [31:0] eMask [2];
      logic [31:0] eAddr [2];
      logic [31:0] eLoad;

      size  = 1 << w;
      off   = int'(addr[1:0]);
      eLoad = '0;
      for (int b = 0; b < 2; b++) begin
         eStrb[b] = '0;
         eWdat[b] = '0;
         eMask[b] = '0;
      end
      eAddr[0] = {addr[31:2], 2'b00};
      eAddr[1] = eAddr[0] + 32'd4;
      fault = 0;
      nb    = 0;
      if (ld == st || w == 2'd3) begin
         fault = 3;
      end else if ((off % size) != 0 && !SPLIT) begin
         fault = 2;
      end else begin
         for (int i = 0; i < size; i++) begin
            lane = (off + i) % 4;
            beat = (off + i) / 4;
            eStrb[beat][lane]       = 1'b1;
            eMask[beat][lane*8 +: 8] = 8'hFF;
            eWdat[beat][lane*8 +: 8] = sdat[i*8 +: 8];
            eLoad[i*8 +: 8]          = (beat == 1) ? r1[lane*8 +: 8] : r0[lane*8 +: 8];
         end
         nb = (off + size > 4) ? 2 : 1;
         if (!uns && size < 4 && eLoad[size*8-1]) eLoad = eLoad | ~((32'd1 << (size*8)) - 32'd1);
         if (errBeat == 1 || (errBeat == 2 && nb == 2)) fault = 1;
         if (errBeat == 1) nb = 1;
      end

      chk({tag, " reqRdy"}, 32'(reqRdy), 1);
      memEn = 1'b1; load = ld; store = st; unsignedFlg = uns;
      memWidth = w; storeDat = sdat; memAddr = addr;
      tick();
      memEn = 1'b0; load = 1'b0; store = 1'b0;
      storeDat = $urandom; memAddr = $urandom;

      for (int b = 0; b < nb; b++) begin
         for (int k = 0; k < reqDly; k++) begin
            chk({tag, " stall vld"},  32'(busReqVld), 1);
            chk({tag, " stall addr"}, busAddr, eAddr[b]);
            chk({tag, " stall strb"}, 32'(busStrb), 32'(eStrb[b]));
            tick();
         end
         chk({tag, " req vld"},  32'(busReqVld), 1);
         chk({tag, " req addr"}, busAddr, eAddr[b]);
         chk({tag, " req strb"}, 32'(busStrb), 32'(eStrb[b]));
         chk({tag, " req we"},   32'(busWe), 32'(st));
         if (st) chk({tag, " req wdat"}, busWdat & eMask[b], eWdat[b]);
         busReqRdy = 1'b1;
         tick();
         busReqRdy = 1'b0;
         for (int k = 0; k < rspDly; k++) begin
            chk({tag, " wait vld"},  32'(busReqVld), 0);
            chk({tag, " wait done"}, 32'(doneVld), 0);
            tick();
         end
         busRspVld = 1'b1;
         busRdat   = (b == 1) ? r1 : r0;
         busRspErr = (errBeat == b + 1);
         tick();
         busRspVld = 1'b0;
         busRspErr = 1'b0;
         busRdat   = $urandom;
      end
      if (nb == 0) chk({tag, " nobus vld"}, 32'(busReqVld), 0);
      chk({tag, " done"},  32'(doneVld), 1);
      chk({tag, " fault"}, 32'(faultCode), 32'(fault));
      if (ld && fault == 0) chk({tag, " loadDat"}, loadDat, eLoad);
      tick();
      chk({tag, " done drop"}, 32'(doneVld), 0);
      chk({tag, " rdy back"},  32'(reqRdy), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      bit   ld, st;
      int   sel;
      rst_n = 1'b0;
      memEn = 1'b0; load = 1'b0; store = 1'b0; unsignedFlg = 1'b0;
      memWidth = 2'd0; storeDat = '0; memAddr = '0;
      busReqRdy = 1'b0; busRspVld = 1'b0; busRspErr = 1'b0; busRdat = '0;
      tick();
      tick();
      chkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      runAccess("stB",    0, 1, 0, 2'd0, 32'h0000_1003, 32'h0000_00AB, 0, 0, 0, 32'h0, 32'h0);
      runAccess("ldHs",   1, 0, 0, 2'd1, 32'h0000_2002, 32'h0,         0, 0, 0, 32'h8001_1234, 32'h0);
      runAccess("ldHu",   1, 0, 1, 2'd1, 32'h0000_2002, 32'h0,         0, 0, 0, 32'h8001_1234, 32'h0);
      runAccess("stall",  0, 1, 0, 2'd2, 32'h0000_4000, 32'hCAFE_F00D, 3, 0, 0, 32'h0, 32'h0);
      runAccess("ldWmis", 1, 0, 0, 2'd2, 32'h0000_3002, 32'h0,         0, 0, 0, 32'hBBAA_0000, 32'h0000_DDCC);
      runAccess("dbl",    1, 0, 0, 2'd3, 32'h0000_5000, 32'h0,         0, 0, 0, 32'h0, 32'h0);
      runAccess("both",   1, 1, 0, 2'd2, 32'h0000_5000, 32'h0,         0, 0, 0, 32'h0, 32'h0);
      runAccess("busErr", 1, 0, 0, 2'd2, 32'h0000_6000, 32'h0,         0, 1, 1, 32'h1234_5678, 32'h0);
      runAccess("hiWrap", 1, 0, 0, 2'd1, 32'hFFFF_FFFF, 32'h0,         1, 1, 0, 32'h7F00_0000, 32'h0000_0080);

      for (int n = 0; n < 200; n++) begin
         sel = int'($urandom_range(0, 15));
         if (sel == 0) begin
            ld = 0; st = 0;
         end else if (sel == 1) begin
            ld = 1; st = 1;
         end else begin
            ld = 1'($urandom); st = ~ld;
         end
         runAccess("rnd", ld, st, 1'($urandom), 2'($urandom), $urandom, $urandom,
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0,
                   $urandom, $urandom);
      end

      // Reset while the request is still waiting for busReqRdy.
      memEn = 1'b1; load = 1'b1; store = 1'b0; memWidth = 2'd2; memAddr = 32'h0000_7000;
      tick();
      memEn = 1'b0; load = 1'b0;
      chk("rstReq vld before", 32'(busReqVld), 1);
      #2 rst_n = 1'b0;
      #1;
      chkAllZero("rstReq");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rstReq rdy", 32'(reqRdy), 1);

      // Reset while waiting for the response; the late response must be ignored.
      memEn = 1'b1; load = 1'b1; store = 1'b0; memWidth = 2'd2; memAddr = 32'h0000_5000;
      tick();
      memEn = 1'b0; load = 1'b0;
      busReqRdy = 1'b1;
      tick();
      busReqRdy = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chkAllZero("rstRsp");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rstRsp rdy", 32'(reqRdy), 1);
      busRspVld = 1'b1;
      busRdat   = 32'hDEAD_BEEF;
      tick();
      busRspVld = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("lateRsp done", 32'(doneVld), 0);
         chk("lateRsp vld",  32'(busReqVld), 0);
         tick();
      end
      runAccess("postRst", 1, 0, 0, 2'd0, 32'h0000_8001, 32'h0, 0, 0, 0, 32'h0000_9C00, 32'h0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
